register_file: RTL and testbench

//   Parametrised multi-entry register file for the datapath. Replaces the

---
 rtl/register_file.sv | 79 +++++++
 tb/tb_register_file.sv | 124 ++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Parametrised flop-based register file: one synchronous write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward inData to a read port addressing the register being written.
module register_file #(
    parameter int WIDTH    = 5,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Load,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  inData,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [WIDTH-1:0]  outDataA,
    output logic [WIDTH-1:0]  outDataB
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] wrSel;
    logic [WIDTH-1:0] storedA;
    logic [WIDTH-1:0] storedB;

    // Decoding by comparing against each index keeps out-of-range addresses harmless.
    always_comb begin
        wrSel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wrSel[i] = Load && (WrAddr == ADDR_W'(i)) && !(ZERO_REG != 0 && i == 0);
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wrSel[i]) begin
                    regs[i] <= inData;
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] readStored(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                val = regs[i];
            end
        end
        return val;
    endfunction

    always_comb begin
        storedA = readStored(RdAddrA);
        storedB = readStored(RdAddrB);
    end

`ifdef REGFILE_BYPASS_EN
    logic wrValid;

    // wrSel already excludes out-of-range and hard-wired-zero targets.
    always_comb begin
        wrValid  = !Clear && (|wrSel);
        outDataA = (wrValid && RdAddrA == WrAddr) ? inData : storedA;
        outDataB = (wrValid && RdAddrB == WrAddr) ? inData : storedB;
    end
`else
    always_comb begin
        outDataA = storedA;
        outDataB = storedB;
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomised and directed checks of register_file against an array-based reference model.
// Two instances: default geometry, and DEPTH=6 with a hard-wired zero register.
module tb_register_file;

    logic       Clock = 1'b0;
    logic       Clear = 1'b0;
    logic       Load = 1'b0;
    logic [2:0] WrAddr = '0;
    logic [4:0] inData = '0;
    logic [2:0] RdAddrA = '0;
    logic [2:0] RdAddrB = '0;
    logic [4:0] outA0, outB0, outA1, outB1;

    int errors = 0;
    int checks = 0;
    bit armed  = 0;

    int mem0 [8];
    int mem1 [8];

    always #5 Clock = ~Clock;

    register_file #(.WIDTH(5), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) dut (
        .Clock(Clock), .Clear(Clear), .Load(Load), .WrAddr(WrAddr), .inData(inData),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .outDataA(outA0), .outDataB(outB0)
    );

    register_file #(.WIDTH(5), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1)) dutZ (
        .Clock(Clock), .Clear(Clear), .Load(Load), .WrAddr(WrAddr), .inData(inData),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .outDataA(outA1), .outDataB(outB1)
    );

    task automatic checkVal(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit canWrite(input int depth, input int zero, input int addr);
        return addr < depth && !(zero != 0 && addr == 0);
    endfunction

    function automatic int expRead(input int mem[8], input int depth, input int zero, input int addr);
        if (addr >= depth) return 0;
        if (zero != 0 && addr == 0) return 0;
`ifdef REGFILE_BYPASS_EN
        if (Load && !Clear && addr == int'(WrAddr) && canWrite(depth, zero, int'(WrAddr)))
            return int'(inData);
`endif
        return mem[addr];
    endfunction

    // Drive one cycle, check the combinational reads, clock it, then advance the model.
    task automatic cycle(input bit clr, input bit ld, input int wa, input int din,
                         input int ra, input int rb);
        Clear   = clr;
        Load    = ld;
        WrAddr  = 3'(wa);
        inData  = 5'(din);
        RdAddrA = 3'(ra);
        RdAddrB = 3'(rb);
        #2;
        if (armed) begin
            checkVal($sformatf("d8.A@%0d", ra), outA0, 5'(expRead(mem0, 8, 0, ra)));
            checkVal($sformatf("d8.B@%0d", rb), outB0, 5'(expRead(mem0, 8, 0, rb)));
            checkVal($sformatf("d6z.A@%0d", ra), outA1, 5'(expRead(mem1, 6, 1, ra)));
            checkVal($sformatf("d6z.B@%0d", rb), outB1, 5'(expRead(mem1, 6, 1, rb)));
        end
        @(posedge Clock);
        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                mem0[i] = 0;
                mem1[i] = 0;
            end
            armed = 1;
        end else if (ld) begin
            if (canWrite(8, 0, wa)) mem0[wa] = din;
            if (canWrite(6, 1, wa)) mem1[wa] = din;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem0[i] = 0;
            mem1[i] = 0;
        end
        @(posedge Clock);
        #1;
        // Reset with a competing write, then sweep all addresses.
        cycle(1, 1, 2, 5, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, i, 7 - i);
        // Basic writes.
        cycle(0, 1, 3, 10, 3, 6);
        cycle(0, 1, 6, 21, 3, 6);
        cycle(0, 0, 0, 0, 3, 6);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, i, i);
        // Hold with garbage data.
        for (int i = 0; i < 3; i++) cycle(0, 0, 3, 31, 3, 6);
        // Read-during-write on the same address.
        cycle(0, 1, 3, 7, 3, 6);
        cycle(0, 0, 0, 0, 3, 3);
        // Clear beats Load.
        cycle(1, 1, 3, 9, 3, 6);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, i, 7 - i);
        // Boundaries: addr 7 is out of range and addr 0 is hard-wired on the DEPTH=6 instance.
        cycle(0, 1, 7, 4, 7, 0);
        cycle(0, 1, 0, 12, 7, 0);
        cycle(0, 1, 5, 31, 7, 0);
        cycle(0, 0, 0, 0, 5, 5);
        cycle(0, 1, 5, 3, 5, 0);
        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 29) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 31),
                  $urandom_range(0, 7), $urandom_range(0, 7));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
